// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/response bundle between two datapath clients and
// the mem_arbiter storage block.
//   req[1:0], we[1:0]     per-requester access request and write enable
//   addr0/addr1, wdata0/1 per-requester address and write data
//   gnt[1:0], rvalid[1:0] one-hot grant and read-data valid
//   rdata                 read data
//   busy                  arbiter is not idle
//   snap                  packed copy of the whole array, entry 0 in the LSBs
// Modports: master = client side, slave = arbiter side.
interface mem_arbiter_if #(
  parameter int DW = 4,
  parameter int AW = 2
) ();
  logic [1:0]               req;
  logic [1:0]               we;
  logic [AW-1:0]            addr0;
  logic [AW-1:0]            addr1;
  logic [DW-1:0]            wdata0;
  logic [DW-1:0]            wdata1;
  logic [1:0]               gnt;
  logic [1:0]               rvalid;
  logic [DW-1:0]            rdata;
  logic                     busy;
  logic [DW*(1<<AW)-1:0]    snap;

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1,
    input  gnt, rvalid, rdata, busy, snap
  );

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1,
    output gnt, rvalid, rdata, busy, snap
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter and sequencer that owns a 2^AW x DW
// register array. Each accepted request runs IDLE -> ACCESS -> RESP, so one
// access completes every three cycles.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset (clears FSM, outputs and array)
//   bus      mem_arbiter_if.slave: req/we/addr/wdata in; gnt/rvalid/rdata/
//            busy/snap out
// Configuration macro: MEM_ARB_FIXED_PRIO_EN -- when defined, requester 0
// always wins a tie; otherwise ties are broken round-robin via last_gnt_r.
module mem_arbiter #(
  parameter int DW = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus
);

  localparam int NUM = 1 << AW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic            last_gnt_r;   // index of the most recent winner
  logic            win_s;        // winner chosen this cycle (valid in IDLE)
  logic            win_r;        // winner of the access in flight
  logic            we_r;
  logic [AW-1:0]   addr_r;
  logic [DW-1:0]   wdata_r;
  logic [1:0]      gnt_r;
  logic [1:0]      gnt_s;
  logic [1:0]      rvalid_r;
  logic [1:0]      rvalid_s;
  logic [DW-1:0]   rdata_r;
  logic            capture_s;    // IDLE -> ACCESS edge
  logic            commit_s;     // ACCESS -> RESP edge
  logic [DW-1:0]   mem_r [NUM];
  logic [DW*NUM-1:0] snap_s;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // Winner selection from the sampled request vector.
  always_comb begin
    win_s = 1'b0;
    case (bus.req)
      2'b01:   win_s = 1'b0;
      2'b10:   win_s = 1'b1;
`ifdef MEM_ARB_FIXED_PRIO_EN
      2'b11:   win_s = 1'b0;
`else
      2'b11:   win_s = ~last_gnt_r;
`endif
      default: win_s = 1'b0;
    endcase
  end

  // Next-state and next-output logic of the access FSM.
  always_comb begin
    state_s   = state_r;
    gnt_s     = 2'b00;
    rvalid_s  = 2'b00;
    capture_s = 1'b0;
    commit_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req != 2'b00) begin
          state_s   = ACCESS;
          gnt_s     = onehot2(win_s);
          capture_s = 1'b1;
        end else begin
          state_s   = IDLE;
        end
      end
      ACCESS: begin
        state_s  = RESP;
        commit_s = 1'b1;
        if (!we_r) begin
          rvalid_s = onehot2(win_r);
        end else begin
          rvalid_s = 2'b00;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      gnt_r    <= 2'b00;
      rvalid_r <= 2'b00;
    end else begin
      state_r  <= state_s;
      gnt_r    <= gnt_s;
      rvalid_r <= rvalid_s;
    end
  end

  // Request capture and round-robin history; fields are latched only on the
  // IDLE -> ACCESS edge so the client may change them afterwards.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_gnt_r <= 1'b1;  // makes requester 0 win the first tie
      win_r      <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
    end else if (capture_s) begin
      last_gnt_r <= win_s;
      win_r      <= win_s;
      we_r       <= bus.we[win_s];
      addr_r     <= win_s ? bus.addr1 : bus.addr0;
      wdata_r    <= win_s ? bus.wdata1 : bus.wdata0;
    end else begin
      last_gnt_r <= last_gnt_r;
      win_r      <= win_r;
      we_r       <= we_r;
      addr_r     <= addr_r;
      wdata_r    <= wdata_r;
    end
  end

  // Storage array and read-data register; both update on the commit edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM; i++) begin
        mem_r[i] <= '0;
      end
      rdata_r <= '0;
    end else if (commit_s) begin
      if (we_r) begin
        mem_r[addr_r] <= wdata_r;
      end else begin
        rdata_r <= mem_r[addr_r];
      end
    end else begin
      rdata_r <= rdata_r;
    end
  end

  // Pack the array into the snapshot bus, entry 0 in the LSBs.
  always_comb begin
    snap_s = '0;
    for (int i = 0; i < NUM; i++) begin
      snap_s[i*DW +: DW] = mem_r[i];
    end
  end

  assign bus.gnt    = gnt_r;
  assign bus.rvalid = rvalid_r;
  assign bus.rdata  = rdata_r;
  assign bus.busy   = (state_r != IDLE);
  assign bus.snap   = snap_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (DW=4, AW=2).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_mem_arbiter;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  mem_arbiter_if #(.DW(4), .AW(2)) bus ();

  mem_arbiter #(.DW(4), .AW(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] w,
                       input logic [1:0] a0, input logic [3:0] d0,
                       input logic [1:0] a1, input logic [3:0] d1);
    bus.req    = r;
    bus.we     = w;
    bus.addr0  = a0;
    bus.wdata0 = d0;
    bus.addr1  = a1;
    bus.wdata1 = d1;
  endtask

  logic [1:0] exp_gnt [4];

  initial begin
    vectors     = 0;
    miscompares = 0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    drive(2'b00, 2'b00, 2'd0, 4'h0, 2'd0, 4'h0);

    // Reset held for two cycles, then idle.
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst_gnt",    {30'd0, bus.gnt},    32'h0);
    chk("rst_rvalid", {30'd0, bus.rvalid}, 32'h0);
    chk("rst_rdata",  {28'd0, bus.rdata},  32'h0);
    chk("rst_snap",   {16'd0, bus.snap},   32'h0);
    chk("rst_busy",   {31'd0, bus.busy},   32'h0);

    // Requester 0 writes 4'hA to entry 2.
    drive(2'b01, 2'b01, 2'd2, 4'hA, 2'd0, 4'h0);
    tick();
    chk("wr0_gnt",  {30'd0, bus.gnt}, 32'h1);
    chk("wr0_busy", {31'd0, bus.busy}, 32'h1);
    drive(2'b00, 2'b00, 2'd0, 4'h0, 2'd0, 4'h0);
    tick();
    chk("wr0_snap",   {16'd0, bus.snap},   32'h0A00);
    chk("wr0_rvalid", {30'd0, bus.rvalid}, 32'h0);
    tick();
    chk("wr0_idle", {31'd0, bus.busy}, 32'h0);

    // Requester 0 reads entry 2 back.
    drive(2'b01, 2'b00, 2'd2, 4'h0, 2'd0, 4'h0);
    tick();
    chk("rd0_gnt", {30'd0, bus.gnt}, 32'h1);
    drive(2'b00, 2'b00, 2'd0, 4'h0, 2'd0, 4'h0);
    tick();
    chk("rd0_rvalid", {30'd0, bus.rvalid}, 32'h1);
    chk("rd0_rdata",  {28'd0, bus.rdata},  32'hA);
    tick();
    chk("rd0_done_rvalid", {30'd0, bus.rvalid}, 32'h0);

    // Fresh reset, then both requesters hold req for four grants.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst2_snap", {16'd0, bus.snap}, 32'h0);
    drive(2'b11, 2'b00, 2'd0, 4'h0, 2'd0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("cont_gnt%0d", k), {30'd0, bus.gnt}, {30'd0, exp_gnt[k]});
      if (k == 3) begin
        bus.req = 2'b00;
      end
      tick();
      chk($sformatf("cont_resp_gnt%0d", k), {30'd0, bus.gnt}, 32'h0);
      tick();
    end
    chk("cont_idle", {31'd0, bus.busy}, 32'h0);

    // Requester 1 writes 4'h5 to entry 1; requester 0 raises a read of
    // entry 1 during ACCESS, which must wait for IDLE.
    drive(2'b10, 2'b10, 2'd0, 4'h0, 2'd1, 4'h5);
    tick();
    chk("wr1_gnt", {30'd0, bus.gnt}, 32'h2);
    drive(2'b01, 2'b00, 2'd1, 4'h0, 2'd0, 4'h0);
    tick();
    chk("wr1_snap",     {16'd0, bus.snap}, 32'h0050);
    chk("late_req_gnt", {30'd0, bus.gnt},  32'h0);
    tick();
    chk("late_req_idle_gnt",  {30'd0, bus.gnt},  32'h0);
    chk("late_req_idle_busy", {31'd0, bus.busy}, 32'h0);
    tick();
    chk("rd1_gnt", {30'd0, bus.gnt}, 32'h1);
    drive(2'b00, 2'b00, 2'd0, 4'h0, 2'd0, 4'h0);
    tick();
    chk("rd1_rvalid", {30'd0, bus.rvalid}, 32'h1);
    chk("rd1_rdata",  {28'd0, bus.rdata},  32'h5);
    tick();

    // Reset lands on the commit edge of a write of 4'hF to entry 3.
    drive(2'b01, 2'b01, 2'd3, 4'hF, 2'd0, 4'h0);
    tick();
    chk("rstw_gnt", {30'd0, bus.gnt}, 32'h1);
    drive(2'b00, 2'b00, 2'd0, 4'h0, 2'd0, 4'h0);
    reset_n = 1'b0;
    tick();
    chk("rstw_snap",   {16'd0, bus.snap},   32'h0);
    chk("rstw_rvalid", {30'd0, bus.rvalid}, 32'h0);
    chk("rstw_busy",   {31'd0, bus.busy},   32'h0);
    chk("rstw_gnt0",   {30'd0, bus.gnt},    32'h0);
    chk("rstw_rdata",  {28'd0, bus.rdata},  32'h0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_gnt", {30'd0, bus.gnt}, 32'h0);
    drive(2'b01, 2'b00, 2'd3, 4'h0, 2'd0, 4'h0);
    tick();
    chk("post_rst_req_gnt", {30'd0, bus.gnt}, 32'h1);
    drive(2'b00, 2'b00, 2'd0, 4'h0, 2'd0, 4'h0);
    tick();
    chk("post_rst_rvalid", {30'd0, bus.rvalid}, 32'h1);
    chk("post_rst_rdata",  {28'd0, bus.rdata},  32'h0);
    tick();
    chk("post_rst_idle", {31'd0, bus.busy}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
